// File: rtl/prog_timer_pkg.sv
// prog_timer shared definitions: register map, CTRL bit positions
// and the per-channel state type.
package prog_timer_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_PER   = 1;
  localparam int CTRL_IE    = 2;
  localparam int CTRL_CHAIN = 3;
  localparam int CTRL_W     = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } ch_state_t;

endpackage

// File: rtl/prog_timer_if.sv
// prog_timer register bus and interrupt bundle.
// Address is {channel, reg[1:0]}.
interface prog_timer_if #(
  parameter int WIDTH  = 16,
  parameter int NUM_CH = 4
);
  localparam int AW = $clog2(NUM_CH) + 2;

  logic              bus_wr;
  logic              bus_rd;
  logic [AW-1:0]     bus_addr;
  logic [WIDTH-1:0]  bus_wdata;
  logic [WIDTH-1:0]  bus_rdata;
  logic              bus_rvalid;
  logic [NUM_CH-1:0] irq_vec;
  logic              irq;

  modport master (
    output bus_wr, bus_rd, bus_addr, bus_wdata,
    input  bus_rdata, bus_rvalid, irq_vec, irq
  );

  modport slave (
    input  bus_wr, bus_rd, bus_addr, bus_wdata,
    output bus_rdata, bus_rvalid, irq_vec, irq
  );

endinterface

// File: rtl/prog_timer_ch.sv
// One prog_timer channel: CTRL/LOAD/COUNT, pending flag and FSM.
// Chain input is honoured only when PROG_TIMER_CHAIN_EN is defined.
module prog_timer_ch
  import prog_timer_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter bit CHAIN_OK = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              chain_in,
  input  logic              wr_ctrl,
  input  logic              wr_load,
  input  logic              w1c,
  input  logic [WIDTH-1:0]  wdata,
  output logic [CTRL_W-1:0] ctrl,
  output logic [WIDTH-1:0]  load,
  output logic [WIDTH-1:0]  count,
  output logic              pending,
  output logic              expire
);

  ch_state_t state;
  logic      evt;
  logic      stop;
  logic      zero;

`ifdef PROG_TIMER_CHAIN_EN
  assign evt = (CHAIN_OK && ctrl[CTRL_CHAIN]) ? chain_in : tick;
`else
  logic unused_chain;
  assign unused_chain = chain_in | CHAIN_OK;
  assign evt = tick;
`endif

  // A disabling CTRL write freezes COUNT and suppresses that edge's event.
  assign stop   = wr_ctrl & ~wdata[CTRL_EN];
  assign zero   = (count == '0);
  assign expire = (state == RUN) & evt & zero & ~stop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ctrl    <= '0;
      load    <= '0;
      count   <= '0;
      pending <= 1'b0;
    end else begin
      if (expire)
        pending <= 1'b1;
      else if (w1c)
        pending <= 1'b0;

      if (wr_load)
        load <= wdata;

      case (state)
        RUN: begin
          if (evt) begin
            if (!zero)
              count <= count - WIDTH'(1);
            else if (ctrl[CTRL_PER])
              count <= load;
            else begin
              state         <= DONE;
              ctrl[CTRL_EN] <= 1'b0;
            end
          end
        end
        DONE:    state <= IDLE;
        default: ;
      endcase

      if (wr_ctrl) begin
        ctrl[CTRL_PER] <= wdata[CTRL_PER];
        ctrl[CTRL_IE]  <= wdata[CTRL_IE];
`ifdef PROG_TIMER_CHAIN_EN
        ctrl[CTRL_CHAIN] <= CHAIN_OK & wdata[CTRL_CHAIN];
`endif
        if (wdata[CTRL_EN] && !ctrl[CTRL_EN]) begin
          ctrl[CTRL_EN] <= 1'b1;
          count         <= load;
          state         <= RUN;
        end else if (!wdata[CTRL_EN]) begin
          ctrl[CTRL_EN] <= 1'b0;
          count         <= count;
          state         <= IDLE;
        end
      end
    end
  end

endmodule

// File: rtl/prog_timer.sv
// Multi-channel programmable down-counter timer with shared prescaler.
// Define PROG_TIMER_CHAIN_EN to let channel i count channel i-1 expiries.
module prog_timer
  import prog_timer_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int NUM_CH   = 4,
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  prog_timer_if.slave bus
);

  localparam int AW = $clog2(NUM_CH) + 2;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]     pcnt;
  logic              tick;
  logic [AW-1:0]     ch_sel;
  logic [1:0]        reg_sel;
  logic [WIDTH-1:0]  rd_mux;
  logic [CTRL_W-1:0] ctrl [NUM_CH];
  logic [WIDTH-1:0]  load [NUM_CH];
  logic [WIDTH-1:0]  count [NUM_CH];
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] expire;
  logic [NUM_CH-1:0] cin;
  logic [NUM_CH-1:0] irq_vec;

  assign tick = (pcnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (reset)     pcnt <= '0;
    else if (tick) pcnt <= '0;
    else           pcnt <= pcnt + PW'(1);
  end

  assign ch_sel  = bus.bus_addr >> 2;
  assign reg_sel = bus.bus_addr[1:0];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic hit;
    assign hit = bus.bus_wr && (ch_sel == AW'(i));

`ifdef PROG_TIMER_CHAIN_EN
    if (i == 0) begin : g_head
      assign cin[i] = 1'b0;
    end else begin : g_link
      assign cin[i] = expire[i-1];
    end
`else
    assign cin[i] = 1'b0;
`endif

    prog_timer_ch #(
      .WIDTH    (WIDTH),
      .CHAIN_OK (i > 0)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .chain_in (cin[i]),
      .wr_ctrl  (hit && reg_sel == REG_CTRL),
      .wr_load  (hit && reg_sel == REG_LOAD),
      .w1c      (hit && reg_sel == REG_STATUS
                 && bus.bus_wdata[0]),
      .wdata    (bus.bus_wdata),
      .ctrl     (ctrl[i]),
      .load     (load[i]),
      .count    (count[i]),
      .pending  (pending[i]),
      .expire   (expire[i])
    );

    assign irq_vec[i] = pending[i] & ctrl[i][CTRL_IE];
  end

  assign bus.irq_vec = irq_vec;
  assign bus.irq     = |irq_vec;

  // Channels beyond NUM_CH never match, so unmapped reads stay 0.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == AW'(i)) begin
        unique case (reg_sel)
          REG_CTRL:   rd_mux = WIDTH'(ctrl[i]);
          REG_LOAD:   rd_mux = load[i];
          REG_COUNT:  rd_mux = count[i];
          REG_STATUS: rd_mux = WIDTH'(pending[i]);
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.bus_rdata  <= '0;
      bus.bus_rvalid <= 1'b0;
    end else begin
      bus.bus_rvalid <= bus.bus_rd;
      if (bus.bus_rd)
        bus.bus_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_prog_timer.sv
// Bench for prog_timer: two instances (PRESCALE 1 and 4), an event-count
// reference model checked every cycle, and directed literal checks.
module tb_prog_timer;
  import prog_timer_pkg::*;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  prog_timer_if #(.WIDTH(W), .NUM_CH(N)) bus0 ();
  prog_timer_if #(.WIDTH(W), .NUM_CH(N)) bus1 ();

  prog_timer #(.WIDTH(W), .NUM_CH(N), .PRESCALE(1)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));
  prog_timer #(.WIDTH(W), .NUM_CH(N), .PRESCALE(4)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));

  logic          wr [2];
  logic          rd [2];
  logic [AW-1:0] addr [2];
  logic [W-1:0]  wdata [2];
  logic [W-1:0]  rdata [2];
  logic          rvalid [2];
  logic [N-1:0]  irqv [2];
  logic          irq [2];

  assign bus0.bus_wr    = wr[0];
  assign bus0.bus_rd    = rd[0];
  assign bus0.bus_addr  = addr[0];
  assign bus0.bus_wdata = wdata[0];
  assign bus1.bus_wr    = wr[1];
  assign bus1.bus_rd    = rd[1];
  assign bus1.bus_addr  = addr[1];
  assign bus1.bus_wdata = wdata[1];
  assign rdata[0]  = bus0.bus_rdata;
  assign rvalid[0] = bus0.bus_rvalid;
  assign irqv[0]   = bus0.irq_vec;
  assign irq[0]    = bus0.irq;
  assign rdata[1]  = bus1.bus_rdata;
  assign rvalid[1] = bus1.bus_rvalid;
  assign irqv[1]   = bus1.irq_vec;
  assign irq[1]    = bus1.irq;

  int ntest = 0;
  int nfail = 0;
  int tcyc  = 0;
  bit chk_on = 1'b0;

  always @(posedge clk) tcyc <= tcyc + 1;

  task automatic chk(string nm, longint act, longint exp);
    ntest++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: a channel counts events since (re)load; it expires
  // when that count reaches LOAD+1. COUNT is LOAD minus events seen.
  bit          m_en   [2][N];
  bit          m_run  [2][N];
  bit          m_per  [2][N];
  bit          m_ie   [2][N];
  bit          m_ch   [2][N];
  bit          m_pend [2][N];
  int unsigned m_load [2][N];
  int unsigned m_L    [2][N];
  int unsigned m_ev   [2][N];
  int unsigned m_frz  [2][N];
  int unsigned mcyc;
  bit          e_rvalid [2];
  int unsigned e_rdata  [2];

  function automatic int ps(int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic int unsigned m_count(int d, int i);
    return m_run[d][i] ? (m_L[d][i] - m_ev[d][i]) : m_frz[d][i];
  endfunction

  function automatic int unsigned m_read(int d, int a);
    int c = a / 4;
    case (a % 4)
      0: return {m_ch[d][c], m_ie[d][c], m_per[d][c], m_en[d][c]};
      1: return m_load[d][c];
      2: return m_count(d, c);
      default: return 32'(m_pend[d][c]);
    endcase
  endfunction

  function automatic logic [N-1:0] m_irqv(int d);
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = m_pend[d][i] & m_ie[d][i];
    return v;
  endfunction

  always @(posedge clk) begin : p_model
    bit tick, pexp, ev, stop, e, en0, hit;
    int c, r;
    if (reset) begin
      mcyc = 0;
      for (int d = 0; d < 2; d++) begin
        e_rvalid[d] = 0;
        e_rdata[d]  = 0;
        for (int i = 0; i < N; i++) begin
          m_en[d][i] = 0; m_run[d][i] = 0; m_per[d][i] = 0;
          m_ie[d][i] = 0; m_ch[d][i] = 0; m_pend[d][i] = 0;
          m_load[d][i] = 0; m_L[d][i] = 0; m_ev[d][i] = 0;
          m_frz[d][i] = 0;
        end
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        tick = (mcyc % ps(d)) == ps(d) - 1;
        e_rvalid[d] = rd[d];
        if (rd[d]) e_rdata[d] = m_read(d, int'(addr[d]));
        c = int'(addr[d]) / 4;
        r = int'(addr[d]) % 4;
        pexp = 0;
        for (int i = 0; i < N; i++) begin
          hit  = wr[d] && c == i;
          stop = hit && r == 0 && !wdata[d][0];
          ev   = tick;
`ifdef PROG_TIMER_CHAIN_EN
          if (i > 0 && m_ch[d][i]) ev = pexp;
`endif
          e   = 0;
          en0 = m_en[d][i];
          if (m_run[d][i] && ev && !stop) begin
            m_ev[d][i]++;
            if (m_ev[d][i] == m_L[d][i] + 1) begin
              e = 1;
              if (m_per[d][i]) begin
                m_ev[d][i] = 0;
                m_L[d][i]  = m_load[d][i];
              end else begin
                m_run[d][i] = 0;
                m_en[d][i]  = 0;
                m_frz[d][i] = 0;
              end
            end
          end
          if (e) m_pend[d][i] = 1;
          else if (hit && r == 3 && wdata[d][0]) m_pend[d][i] = 0;
          if (hit && r == 1) m_load[d][i] = wdata[d];
          if (hit && r == 0) begin
            m_per[d][i] = wdata[d][1];
            m_ie[d][i]  = wdata[d][2];
`ifdef PROG_TIMER_CHAIN_EN
            m_ch[d][i]  = (i > 0) && wdata[d][3];
`endif
            if (wdata[d][0] && !en0) begin
              m_en[d][i]  = 1;
              m_run[d][i] = 1;
              m_ev[d][i]  = 0;
              m_L[d][i]   = m_load[d][i];
            end else if (!wdata[d][0]) begin
              if (m_run[d][i]) m_frz[d][i] = m_L[d][i] - m_ev[d][i];
              m_run[d][i] = 0;
              m_en[d][i]  = 0;
            end
          end
          pexp = e;
        end
      end
      mcyc++;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        chk("m_irq_vec", irqv[d], m_irqv(d));
        chk("m_irq", irq[d], |m_irqv(d));
        chk("m_rvalid", rvalid[d], e_rvalid[d]);
        chk("m_rdata", rdata[d], e_rdata[d]);
      end
    end
  end

  task automatic wr_reg(int d, int a, int v);
    wr[d] = 1; addr[d] = AW'(a); wdata[d] = W'(v);
    @(negedge clk);
    wr[d] = 0;
  endtask

  task automatic rd_chk(int d, int a, int v, string nm);
    rd[d] = 1; addr[d] = AW'(a);
    @(negedge clk);
    rd[d] = 0;
    chk(nm, rdata[d], v);
  endtask

  task automatic wait_irq(int d, int b, output int t);
    int k = 0;
    while (!irqv[d][b] && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("irq_wait", irqv[d][b], 1);
    t = tcyc;
  endtask

  task automatic per_run(int b, int per, int mask, string nm);
    int t;
    int tp = 0;
    for (int k = 0; k < 3; k++) begin
      wait_irq(0, b, t);
      chk({nm, "_vec"}, irqv[0], mask);
      if (k > 0) chk({nm, "_period"}, t - tp, per);
      tp = t;
      wr_reg(0, b * 4 + 3, 1);
      chk({nm, "_clr"}, irqv[0], 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    for (int d = 0; d < 2; d++) begin
      wr[d] = 1; rd[d] = 0; addr[d] = AW'(1); wdata[d] = W'(16'h00ff);
    end
    @(negedge clk);
    chk_on = 1;
    @(negedge clk);
    reset = 0;
    wr[0] = 0;
    wr[1] = 0;

    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 16; a++)
        rd_chk(d, a, 0, "rst_reg");

    // One-shot on dut0 ch0
    wr_reg(0, 1, 3);
    wr_reg(0, 0, 5);
    rd_chk(0, 2, 3, "os_cnt3");
    rd_chk(0, 2, 2, "os_cnt2");
    rd_chk(0, 2, 1, "os_cnt1");
    rd_chk(0, 2, 0, "os_cnt0");
    chk("os_irq", irq[0], 1);
    chk("os_vec", irqv[0], 1);
    rd_chk(0, 0, 4, "os_ctrl");
    wr_reg(0, 2, 16'h55);
    rd_chk(0, 2, 0, "cnt_ro");
    wr_reg(0, 3, 0);
    chk("w1c_zero", irq[0], 1);
    wr_reg(0, 3, 1);
    chk("w1c_clr", irq[0], 0);

    wr[0] = 1; rd[0] = 1; addr[0] = AW'(1); wdata[0] = W'(9);
    @(negedge clk);
    wr[0] = 0; rd[0] = 0;
    chk("wrrd_old", rdata[0], 3);
    rd_chk(0, 1, 9, "wrrd_new");

    // Periodic on dut0 ch1, then W1C colliding with expiry
    wr_reg(0, 5, 2);
    wr_reg(0, 4, 7);
    per_run(1, 3, 2, "per");
    @(negedge clk);
    wr_reg(0, 7, 1);
    chk("coll_pend", irqv[0], 2);
    rd_chk(0, 7, 1, "coll_stat");
    wr_reg(0, 4, 0);
    wr_reg(0, 7, 1);
    chk("coll_clr", irqv[0], 0);

    // Prescale 4 on dut1 ch2: enable on a tick edge, disable 12 later
    wr_reg(1, 9, 10);
    while ((mcyc % 4) != 3) @(negedge clk);
    wr_reg(1, 8, 1);
    repeat (11) @(negedge clk);
    wr_reg(1, 8, 0);
    rd_chk(1, 10, 8, "ps_frz");
    repeat (5) @(negedge clk);
    rd_chk(1, 10, 8, "ps_hold");
    wr_reg(1, 8, 1);
    rd_chk(1, 10, 10, "ps_reload");
    repeat (50) @(negedge clk);
    rd_chk(1, 11, 1, "ps_pend");
    chk("ps_irq_off", irq[1], 0);
    wr_reg(1, 8, 4);
    chk("ps_irq_on", irq[1], 1);
    chk("ps_vec", irqv[1], 4);
    rd_chk(1, 10, 0, "ps_done_cnt");
    wr_reg(1, 11, 1);
    chk("ps_clr", irq[1], 0);

`ifdef PROG_TIMER_CHAIN_EN
    wr_reg(0, 1, 0);
    wr_reg(0, 5, 1);
    wr_reg(0, 4, 15);
    wr_reg(0, 0, 3);
    per_run(1, 2, 2, "chain");
    rd_chk(0, 4, 15, "chain_ctrl");
    wr_reg(0, 0, 11);
    rd_chk(0, 0, 3, "ch0_bit3");
    wr_reg(0, 0, 0);
    wr_reg(0, 4, 0);
    wr_reg(0, 7, 1);
`else
    wr_reg(0, 4, 8);
    rd_chk(0, 4, 0, "nochain_bit3");
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule

// File: doc/prog_timer.md
# prog_timer

Multi-channel programmable down-counter timer, the parametrised successor to the fixed 8-bit 0x0F-to-0 SoC timer. It provides NUM_CH independent channels, each with a software-loaded reload value, one-shot or periodic mode, a per-channel interrupt enable and a sticky write-1-to-clear pending flag. A shared prescaler divides the system clock. It sits on the SoC register bus and drives the SoC interrupt input.

## Interface
- WIDTH, 16: counter, LOAD and bus data width; minimum 8.
- NUM_CH, 4: number of channels, 1..8.
- PRESCALE, 1: clock divide ratio for the shared tick, at least 1.
- clk  in  1  system clock.
- reset  in  1  reset; one clock; reset is synchronous and active-high.
- bus_wr  in  1  write strobe, one cycle per access.
- bus_rd  in  1  read strobe, one cycle per access.
- bus_addr  in  $clog2(NUM_CH)+2  {channel, reg[1:0]}.
- bus_wdata  in  WIDTH  write data.
- bus_rdata  out  WIDTH  read data, registered.
- bus_rvalid  out  1  high exactly one cycle after bus_rd.
- irq_vec  out  NUM_CH  per-channel interrupt, pending[i] & irq_en[i].
- irq  out  1  OR of irq_vec.

## Operation
- Per-channel registers:
  - reg 0 CTRL (rw): bit0 enable, bit1 periodic, bit2 irq_en, bit3 chain (see Configuration). Other bits read 0.
  - reg 1 LOAD (rw).
  - reg 2 COUNT (ro; writes ignored).
  - reg 3 STATUS: bit0 pending; writing 1 clears it, writing 0 has no effect.
- Prescaler: a counter counts 0..PRESCALE-1. tick is asserted in the cycle the counter equals PRESCALE-1, then the counter wraps to 0. With PRESCALE=1, tick is high every cycle.
- Channel FSM:
  - IDLE: enable=0, COUNT held.
  - RUN: counting.
  - DONE: one-shot expired; COUNT=0, enable auto-cleared, next state IDLE.
- Transitions:
  - CTRL write with enable 0->1 sets COUNT<=LOAD and enters RUN.
  - CTRL write with enable 1->1 does not reload.
  - CTRL write with enable=0 enters IDLE and freezes COUNT.
- RUN, on a count event (tick, or the chain source when chaining):
  - If COUNT!=0, COUNT<=COUNT-1.
  - If COUNT==0, the channel expires: pending<=1.
    - Periodic: COUNT<=LOAD, stay in RUN.
    - One-shot: enter DONE.
  - Expiry period is LOAD+1 events. LOAD=0 in periodic mode expires on every event.
- A LOAD write during RUN takes effect only at the next reload or enable.
- If an expiry and a STATUS W1C to the same channel occur in the same cycle, the set wins and pending stays 1.
- Arithmetic is unsigned modulo 2^WIDTH. Decrement never underflows because 0 always triggers expiry.
- Reads:
  - bus_rdata is registered from the register state before that edge's updates.
  - Unmapped addresses (channel >= NUM_CH) read 0; writes to them are ignored.
  - If bus_wr and bus_rd are both high, both are performed.
- Reset mid-operation: all state returns to reset values at the next edge; reset overrides any bus write in the same cycle.

## Timing
- Reset values are 0 for: all CTRL, LOAD, COUNT, pending, the prescaler counter, bus_rdata, bus_rvalid, irq_vec and irq.
- An enable write accepted at edge E0 loads COUNT. With PRESCALE=1, the first expiry sets pending at edge E0+LOAD+1.
- irq_vec and irq are combinational from registered pending and irq_en, so they are valid immediately after the setting edge.
- Read latency is 1 cycle: bus_rd at edge N gives bus_rvalid and bus_rdata valid after edge N+1. bus_rdata holds until the next read.
- STATUS W1C at edge N drops irq after edge N, unless a simultaneous expiry occurs.

## Configuration
- PROG_TIMER_CHAIN_EN defined:
  - CTRL bit3 is implemented for channels 1..NUM_CH-1.
  - When set, the channel's count event is the expiry pulse of channel i-1 instead of tick.
  - Channel 0 bit3 reads 0.
- PROG_TIMER_CHAIN_EN undefined:
  - Bit3 reads 0 and is ignored on write.
  - All channels count on tick.
  - No chain logic is synthesised.

## Structure
- prog_timer_pkg holds:
  - register offsets (REG_CTRL=0, REG_LOAD=1, REG_COUNT=2, REG_STATUS=3);
  - CTRL bit positions (CTRL_EN, CTRL_PER, CTRL_IE, CTRL_CHAIN);
  - the channel state typedef {IDLE, RUN, DONE}.
- Sub-module prog_timer_ch holds one channel: FSM, COUNT, LOAD, CTRL, pending, and expiry pulse out.
- The top level holds the prescaler, address decode, read mux, irq OR and the chain wiring, with a generate loop over NUM_CH.

## Test plan
- Reset: assert reset for 2 cycles with bus_wr active. Required: all outputs 0, and reading CTRL/LOAD/COUNT/STATUS of every channel returns 0.
- One-shot (PRESCALE=1): ch0 LOAD=3, then CTRL=0x5. Required: COUNT reads 3,2,1,0; pending and irq rise at E0+4; CTRL then reads 0x4 (enable auto-cleared).
- Periodic: ch1 LOAD=2, CTRL=0x7, W1C after each expiry. Required: pending sets every 3 cycles, and irq_vec=4'b0010 only while pending.
- Collision: W1C to ch1 STATUS in the same cycle as its expiry. Required: pending remains 1.
- Disable and prescale (PRESCALE=4): ch2 LOAD=10, enable, then disable after 12 cycles. Required: COUNT frozen at 8; re-enable reloads 10; irq_en=0 keeps irq low while pending=1.
- Chain (PROG_TIMER_CHAIN_EN): ch0 periodic LOAD=0; ch1 periodic LOAD=1 with chain. Required: ch1 expires on every 2nd ch0 expiry.
